jk_down_counter: RTL

Parameterised synchronous down-counter built from JK flip-flop cells. It is the decrementing counterpart of the team's JK-based synchronous up-counter. It supports parallel load, a stored reload value, wrap or auto-reload at zero, and cascade/terminal-count outputs. It serves as the tick/timeout generator in lab sequencers and chains with further stages through `borrow`.

---
 rtl/jk_down_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/jk_down_counter.sv
// ---------------------------------------------------------------------------
// jk_down_counter
//
// Synchronous down-counter whose count bits are JK flip-flop cells. Supports
// parallel load, a stored reload value, wrap-to-all-ones or auto-reload when
// stepping past zero, and cascade (borrow) / terminal-count (tc) outputs.
// Used as a tick/timeout generator; wider counters are built by chaining
// stages with the next stage's en driven from this stage's borrow.
//
// Parameters:
//   WIDTH      counter width in bits, legal range 2..16
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous, active-high reset (q, reload register, tc -> 0)
//   en         count enable, one decrement step per enabled edge
//   load       parallel load strobe (wins over en)
//   load_val   value loaded into q and into the reload register
//   reload_en  at-zero behaviour: 0 = wrap to all-ones, 1 = reload value
//   q          current count, registered
//   zero       combinational, q == 0
//   borrow     combinational, en & ~load & zero (cascade enable)
//   tc         registered, high for the first cycle q reads 0 after a step
// ---------------------------------------------------------------------------
module jk_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             reload_en,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             tc
);

    // Count bits (JK cells), stored reload value and terminal-count flop.
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] rld_q;
    logic [WIDTH-1:0] rld_d;
    logic             tc_q;
    logic             tc_d;

    // J and K inputs of each cell.
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // Running "all lower bits are zero" term used to build the toggle chain.
    logic             low_zero;

    assign zero   = (cnt_q == '0);
    assign borrow = en & ~load & zero;
    assign q      = cnt_q;
    assign tc     = tc_q;

    // Cell excitation. Load is expressed as J=val/K=~val so that every change
    // of a count bit goes through the JK characteristic equation below.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        j        = '0;
        k        = '0;
        low_zero = 1'b1;
        if (load) begin
            j = load_val;
            k = ~load_val;
        end else if (en) begin
            if (zero && reload_en) begin
                // Force each cell to the stored reload value.
                j = rld_q;
                k = ~rld_q;
            end else begin
                // Down-count: cell i toggles when all bits below it are 0.
                // At zero every cell toggles, which yields all-ones (wrap).
                for (int i = 0; i < WIDTH; i++) begin
                    j[i]     = low_zero;
                    k[i]     = low_zero;
                    low_zero = low_zero & ~cnt_q[i];
                end
            end
        end

        // JK characteristic: Q+ = J & ~Q | ~K & Q.
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = (j[i] & ~cnt_q[i]) | (~k[i] & cnt_q[i]);
        end
    end

    assign rld_d = load ? load_val : rld_q;

    // tc is set only when an enabled, non-load step takes q from 1 to 0, so a
    // direct load of 0 or a reload-from-zero never raises it.
    assign tc_d  = en & ~load & (cnt_q == WIDTH'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, independent of statement order.
        if (rst) begin
            cnt_q <= '0;
            rld_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
            tc_q  <= tc_d;
        end
    end

endmodule
